// File: rtl/des_pkg.sv
// des_pkg: DES index tables, shift schedule, FSM states and bit-order helpers
package des_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    localparam int E_TAB [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

    localparam int P_TAB [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    function automatic logic [63:0] des_conv(input logic [63:0] v);
        logic [63:0] o;
        for (int i = 0; i < 64; i++) o[i] = v[63 - i];
        return o;
    endfunction

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] o;
        for (int i = 0; i < 56; i++) o[i] = k[6'(PC1_TAB[i] - 1)];
        return o;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] o;
        for (int i = 0; i < 48; i++) o[i] = cd[6'(PC2_TAB[i] - 1)];
        return o;
    endfunction

    function automatic logic [27:0] rot28(input logic [27:0] v, input logic [1:0] s, input logic right);
        logic [55:0] w;
        w = right ? {v, v} << s : {v, v} >> s;
        return right ? w[55:28] : w[27:0];
    endfunction
endpackage

// File: rtl/des_f_function.sv
// des_f_function: combinational DES round function (E, key mix, S1-S8, P)
module des_f_function
    import des_pkg::*;
(
    input  logic [31:0] i_r,
    input  logic [47:0] i_k,
    output logic [31:0] o_f
);
    logic [47:0] x;
    logic [31:0] s;

    always_comb begin
        for (int i = 0; i < 48; i++) x[i] = i_r[5'(E_TAB[i] - 1)] ^ i_k[i];
    end

    for (genvar j = 0; j < 8; j++) begin : g_sbox
        logic [5:0] idx;
        logic [3:0] nib;
        assign idx = {x[6*j], x[6*j+5], x[6*j+1], x[6*j+2], x[6*j+3], x[6*j+4]};
        assign nib = 4'(SBOX[j] >> {~idx, 2'b00});
        assign s[4*j +: 4] = {nib[0], nib[1], nib[2], nib[3]};
    end

    always_comb begin
        for (int i = 0; i < 32; i++) o_f[i] = s[5'(P_TAB[i] - 1)];
    end
endmodule

// File: rtl/des_round_engine.sv
// des_round_engine: iterative 16-round DES Feistel core with on-the-fly key schedule
module des_round_engine
    import des_pkg::*;
#(
    parameter int NUM_ROUNDS = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_decrypt,
    input  logic [63:0] i_key,
    input  logic [63:0] i_permuted_text,
    output logic        o_busy,
    output logic        o_done,
    output logic [63:0] o_preoutput
);
    state_e      state_q, state_d;
    logic [31:0] l_q, l_d, r_q, r_d, f_out;
    logic [27:0] c_q, c_d, d_q, d_d, c_rot, d_rot;
    logic [4:0]  round_q, round_d;
    logic        dec_q, dec_d;
    logic [63:0] pre_q, pre_d;
    logic [47:0] subkey;
    logic [3:0]  sh_idx;
    logic [1:0]  sh;

    always_comb begin
        sh_idx = dec_q ? 4'(5'd17 - round_q) : 4'(round_q - 5'd1);
        sh = (dec_q && round_q == 5'd1) ? 2'd0 : 2'(SHIFTS[sh_idx]);
        c_rot = rot28(c_q, sh, dec_q);
        d_rot = rot28(d_q, sh, dec_q);
        subkey = pc2({d_rot, c_rot});
    end

    des_f_function u_f (
        .i_r(r_q),
        .i_k(subkey),
        .o_f(f_out)
    );

    always_comb begin
        state_d = state_q;
        l_d = l_q;
        r_d = r_q;
        c_d = c_q;
        d_d = d_q;
        round_d = round_q;
        dec_d = dec_q;
        pre_d = pre_q;
        if (i_start && state_q != ST_RUN) begin
            state_d = ST_RUN;
            l_d = i_permuted_text[31:0];
            r_d = i_permuted_text[63:32];
            {d_d, c_d} = pc1(i_key);
            round_d = 5'd1;
            dec_d = i_decrypt;
        end else if (state_q == ST_RUN) begin
            l_d = r_q;
            r_d = l_q ^ f_out;
            c_d = c_rot;
            d_d = d_rot;
            round_d = round_q + 5'd1;
            if (round_q == 5'(NUM_ROUNDS)) begin
                state_d = ST_DONE;
                pre_d = {r_q, l_q ^ f_out};
            end
        end else if (state_q == ST_DONE) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            l_q <= '0;
            r_q <= '0;
            c_q <= '0;
            d_q <= '0;
            round_q <= '0;
            dec_q <= 1'b0;
            pre_q <= '0;
        end else begin
            state_q <= state_d;
            l_q <= l_d;
            r_q <= r_d;
            c_q <= c_d;
            d_q <= d_d;
            round_q <= round_d;
            dec_q <= dec_d;
            pre_q <= pre_d;
        end
    end

    assign o_busy = state_q == ST_RUN;
    assign o_done = state_q == ST_DONE;
    assign o_preoutput = pre_q;
endmodule

// File: tb/tb_des_round_engine.sv
// tb_des_round_engine: directed and randomized checks of the DES round engine against a DES-notation model
module tb_des_round_engine;
    import des_pkg::*;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic        i_decrypt;
    logic [63:0] i_key;
    logic [63:0] i_permuted_text;
    logic        o_busy;
    logic        o_done;
    logic [63:0] o_preoutput;

    int checks = 0;
    int errors = 0;

    localparam int IP_TAB [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

    des_round_engine #(.NUM_ROUNDS(16)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_start(i_start),
        .i_decrypt(i_decrypt),
        .i_key(i_key),
        .i_permuted_text(i_permuted_text),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_preoutput(o_preoutput)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All model values use standard DES notation: bit 1 is the MSB.
    function automatic logic [63:0] ip(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 1; i <= 64; i++) y[64 - i] = x[64 - IP_TAB[i - 1]];
        return y;
    endfunction

    function automatic logic [63:0] fp(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 1; i <= 64; i++) y[64 - IP_TAB[i - 1]] = x[64 - i];
        return y;
    endfunction

    function automatic logic [63:0] model(input logic [63:0] key, input logic [63:0] blk, input logic dec);
        logic [55:0] cd;
        logic [47:0] ks [16];
        logic [47:0] kk, x;
        logic [31:0] l, r, s, f, t;
        logic [5:0]  b;
        int sh, src, half, pos, idx;
        for (int i = 1; i <= 56; i++) cd[56 - i] = key[64 - PC1_TAB[i - 1]];
        sh = 0;
        for (int rd = 0; rd < 16; rd++) begin
            sh += SHIFTS[rd];
            for (int i = 1; i <= 48; i++) begin
                src = PC2_TAB[i - 1];
                half = (src > 28) ? 28 : 0;
                pos = (src - 1 - half + sh) % 28 + half + 1;
                ks[rd][48 - i] = cd[56 - pos];
            end
        end
        l = blk[63:32];
        r = blk[31:0];
        for (int rd = 0; rd < 16; rd++) begin
            kk = ks[dec ? 15 - rd : rd];
            for (int i = 1; i <= 48; i++) x[48 - i] = r[32 - E_TAB[i - 1]] ^ kk[48 - i];
            for (int j = 0; j < 8; j++) begin
                b = x[47 - 6 * j -: 6];
                idx = {b[5], b[0]} * 16 + b[4:1];
                s[31 - 4 * j -: 4] = 4'(SBOX[j] >> (4 * (63 - idx)));
            end
            for (int i = 1; i <= 32; i++) f[32 - i] = s[32 - P_TAB[i - 1]];
            t = l ^ f;
            l = r;
            r = t;
        end
        return {r, l};
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [63:0] key_hex, input logic [63:0] blk_hex, input logic dec);
        @(negedge clk);
        i_start = 1'b1;
        i_key = des_conv(key_hex);
        i_permuted_text = des_conv(blk_hex);
        i_decrypt = dec;
        @(negedge clk);
        i_start = 1'b0;
        i_key = rnd64();
        i_permuted_text = rnd64();
        i_decrypt = 1'($urandom);
    endtask

    task automatic wait_done(input int poke, output int cyc, output int bad);
        cyc = 0;
        bad = 0;
        while (o_done !== 1'b1 && cyc < 40) begin
            if (o_busy !== 1'b1) bad++;
            i_start = poke >= 0 && (cyc == poke || cyc == poke + 6);
            if (i_start) begin
                i_key = rnd64();
                i_permuted_text = rnd64();
                i_decrypt = 1'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        i_start = 1'b0;
    endtask

    task automatic run_block(input string tag, input logic [63:0] key_hex, input logic [63:0] blk_hex,
                             input logic dec, input int poke, output logic [63:0] pre_hex);
        int cyc, bad;
        start(key_hex, blk_hex, dec);
        wait_done(poke, cyc, bad);
        check({tag, " latency"}, 64'(cyc), 64'd16);
        check({tag, " busy in run"}, 64'(bad), 64'd0);
        check({tag, " result"}, o_preoutput, des_conv(model(key_hex, blk_hex, dec)));
        check({tag, " busy at done"}, 64'(o_busy), 64'd0);
        pre_hex = des_conv(o_preoutput);
    endtask

    initial begin
        logic [63:0] kat_key, pre, ka, pa, kb, pb, pt, c1, wk;
        int cyc, bad, n;
        rst = 1'b1;
        i_start = 1'b0;
        i_decrypt = 1'b0;
        i_key = '0;
        i_permuted_text = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(o_busy), 64'd0);
        check("reset done", 64'(o_done), 64'd0);
        check("reset preoutput", o_preoutput, 64'd0);
        rst = 1'b0;

        kat_key = 64'h133457799BBCDFF1;
        run_block("kat enc", kat_key, ip(64'h0123456789ABCDEF), 1'b0, -1, pre);
        check("kat enc value", pre, 64'h0A4CD99543423234);
        @(negedge clk);
        check("kat done pulse", 64'(o_done), 64'd0);
        check("kat idle busy", 64'(o_busy), 64'd0);
        check("kat hold", des_conv(o_preoutput), 64'h0A4CD99543423234);

        run_block("kat dec", kat_key, ip(64'h85E813540F0AB405), 1'b1, -1, pre);
        check("kat dec value", pre, ip(64'h0123456789ABCDEF));

        ka = rnd64();
        pa = rnd64();
        kb = rnd64();
        pb = rnd64();
        run_block("b2b first", ka, pa, 1'b0, -1, pre);
        i_start = 1'b1;
        i_key = des_conv(kb);
        i_permuted_text = des_conv(pb);
        i_decrypt = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_key = rnd64();
        check("b2b reload busy", 64'(o_busy), 64'd1);
        check("b2b hold first", o_preoutput, des_conv(model(ka, pa, 1'b0)));
        wait_done(-1, cyc, bad);
        check("b2b gap", 64'(cyc + 1), 64'd17);
        check("b2b second busy", 64'(bad), 64'd0);
        check("b2b second result", o_preoutput, des_conv(model(kb, pb, 1'b1)));

        start(rnd64(), rnd64(), 1'b0);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", 64'(o_busy), 64'd0);
        check("abort preoutput", o_preoutput, 64'd0);
        check("abort done", 64'(o_done), 64'd0);
        n = 0;
        repeat (25) begin
            @(negedge clk);
            if (o_done === 1'b1) n++;
        end
        check("abort no done", 64'(n), 64'd0);
        run_block("after abort", rnd64(), rnd64(), 1'b0, -1, pre);

        run_block("ignore start", rnd64(), rnd64(), 1'b1, 3, pre);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (o_done === 1'b1) n++;
        end
        check("ignore single done", 64'(n), 64'd0);

        wk = 64'h0101010101010101;
        pt = rnd64();
        run_block("weak first", wk, ip(pt), 1'b0, -1, pre);
        c1 = fp(pre);
        @(negedge clk);
        check("weak done pulse", 64'(o_done), 64'd0);
        run_block("weak second", wk, ip(c1), 1'b0, -1, pre);
        check("weak roundtrip", fp(pre), pt);

        for (int i = 0; i < 6; i++) begin
            ka = rnd64();
            pt = rnd64();
            run_block("rand enc", ka, ip(pt), 1'b0, -1, pre);
            run_block("rand dec", ka, ip(fp(pre)), 1'b1, -1, pre);
            check("rand roundtrip", fp(pre), pt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
